// File: rtl/bram_pkg.sv
// Shared definitions for the block-RAM stream reader: FSM states and default geometry.
package bram_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_DATA_LEN   = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/stream_skid2.sv
// Two-entry valid/ready buffer: head register drives the stream, tail absorbs
// the one extra word that can land while the consumer stalls.
module stream_skid2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             out_ready,
    output logic [1:0]       occ,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic [1:0]       occ_q;
    logic             take;

    assign out_valid = (occ_q != 2'd0);
    assign take      = out_valid & out_ready;
    assign occ       = occ_q;
    assign out_data  = head;

    // The reader's credit check guarantees no push arrives while full without a pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            occ_q <= 2'd0;
        end else begin
            unique case ({push, take})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        head <= push_data;
                    end else begin
                        tail <= push_data;
                    end
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    occ_q <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        head <= push_data;
                    end else begin
                        head <= tail;
                        tail <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/bram_stream_reader.sv
// Sequential block-RAM reader presenting words on a valid/ready stream.
// Define BRAM_READER_LAST_EN to add the m_last end-of-command marker.
module bram_stream_reader
    import bram_pkg::*;
#(
    parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int  DATA_LEN   = DEFAULT_DATA_LEN,
    localparam int ADDR_W     = $clog2(DATA_LEN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       count,
    output logic                  busy,
    output logic                  done,
    output logic                  r_en,
    output logic [ADDR_W-1:0]     r_addr,
    input  logic [DATA_WIDTH-1:0] r_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
`ifdef BRAM_READER_LAST_EN
    ,
    output logic                  m_last
`endif
);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remain;
    logic              inflight;
    logic              zero_done;
    logic [1:0]        occ;
    logic              pop;
    logic [2:0]        level;
    logic              issue;
    logic              drain_empty;
    logic              final_issue;

    // Occupancy the buffer will have after this cycle; a new read only lands a cycle later.
    assign pop         = m_valid & m_ready;
    assign level       = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign issue       = (state == RUN) && (level < 3'd2);
    assign final_issue = issue && (remain == {{ADDR_W{1'b0}}, 1'b1});
    assign drain_empty = (state == DRAIN) && (occ == 2'd0) && !inflight;

    assign r_en   = issue;
    assign r_addr = addr;
    assign done   = zero_done | drain_empty;
    assign busy   = (state != IDLE) && !drain_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            remain    <= '0;
            inflight  <= 1'b0;
            zero_done <= 1'b0;
        end else begin
            inflight  <= issue;
            zero_done <= 1'b0;
            unique case (state)
                IDLE, DRAIN: begin
                    // The done cycle of a drain doubles as an idle cycle so back-to-back commands lose nothing.
                    if (state == IDLE || drain_empty) begin
                        state <= IDLE;
                        if (start) begin
                            addr   <= base_addr;
                            remain <= count;
                            if (count != '0) begin
                                state <= RUN;
                            end else begin
                                zero_done <= 1'b1;
                            end
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        addr   <= addr + ADDR_W'(1);
                        remain <= remain - (ADDR_W + 1)'(1);
                        if (final_issue) begin
                            state <= DRAIN;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef BRAM_READER_LAST_EN
    localparam int BUF_W = DATA_WIDTH + 1;
    logic             inflight_last;
    logic [BUF_W-1:0] buf_in;
    logic [BUF_W-1:0] buf_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_last <= 1'b0;
        end else begin
            inflight_last <= final_issue;
        end
    end

    assign buf_in = {inflight_last, r_data};
    assign m_data = buf_out[DATA_WIDTH-1:0];
    assign m_last = buf_out[DATA_WIDTH] & m_valid;
`else
    localparam int BUF_W = DATA_WIDTH;
    logic [BUF_W-1:0] buf_in;
    logic [BUF_W-1:0] buf_out;

    assign buf_in = r_data;
    assign m_data = buf_out;
`endif

    stream_skid2 #(
        .WIDTH(BUF_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight),
        .push_data(buf_in),
        .out_ready(m_ready),
        .occ      (occ),
        .out_valid(m_valid),
        .out_data (buf_out)
    );

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a behavioural RAM preloaded mem[i]=i.
// m_last checks are active when BRAM_READER_LAST_EN is defined.
module tb_bram_stream_reader;

    localparam int DW = 16;
    localparam int DL = 256;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;
    logic          busy;
    logic          done;
    logic          r_en;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
`ifdef BRAM_READER_LAST_EN
    logic          m_last;
`endif

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [DL];

    typedef struct {
        logic [7:0] base;
        int         cnt;
        int         mode;
        int         exp_done;
        int         intr_cyc;
    } vec_t;

    vec_t vecs [7];

    bram_stream_reader #(
        .DATA_WIDTH(DW),
        .DATA_LEN  (DL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_addr(base_addr),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .r_en     (r_en),
        .r_addr   (r_addr),
        .r_data   (r_data),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready)
`ifdef BRAM_READER_LAST_EN
        ,
        .m_last   (m_last)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (r_en) r_data <= mem[r_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int            hs;
        int            issued;
        int            max_out;
        int            stall_bad;
        int            addr_bad;
        int            done_cyc;
        int            exp_addr;
        logic          prev_stall;
        logic [DW-1:0] prev_data;

        @(negedge clk);
        base_addr = v.base;
        count     = 9'(v.cnt);
        start     = 1'b1;
        m_ready   = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        hs         = 0;
        issued     = 0;
        max_out    = 0;
        stall_bad  = 0;
        addr_bad   = 0;
        done_cyc   = -1;
        exp_addr   = int'(v.base);
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int cyc = 1; cyc <= 3000 && done_cyc < 0; cyc++) begin
            case (v.mode)
                1:       m_ready = 1'($urandom_range(0, 1));
                2:       m_ready = (cyc >= 7);
                default: m_ready = 1'b1;
            endcase
            if (v.intr_cyc == cyc) begin
                start     = 1'b1;
                base_addr = 8'h99;
                count     = 9'd7;
            end else begin
                start = 1'b0;
            end
            #1;
            if (cyc == 1) checkOutput("busy_first_cycle", busy, v.cnt != 0);
            if (prev_stall && !(m_valid && m_data == prev_data)) stall_bad++;
            if (r_en) begin
                if (r_addr != exp_addr[7:0]) addr_bad++;
                exp_addr++;
                issued++;
            end
            if (m_valid && m_ready) begin
                checkOutput("word_data", m_data, (int'(v.base) + hs) % 256);
`ifdef BRAM_READER_LAST_EN
                checkOutput("m_last", m_last, hs == v.cnt - 1);
`endif
                hs++;
            end
            if (issued - hs > max_out) max_out = issued - hs;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (done) begin
                done_cyc = cyc;
                checkOutput("busy_low_at_done", busy, 0);
            end
            @(negedge clk);
        end
        start = 1'b0;
        #1;
        checkOutput("done_single_pulse", done, 0);
        checkOutput("done_seen", done_cyc >= 0, 1);
        if (v.exp_done >= 0) checkOutput("done_cycle", done_cyc, v.exp_done);
        checkOutput("word_count", hs, v.cnt);
        checkOutput("read_count", issued, v.cnt);
        checkOutput("read_addr_errs", addr_bad, 0);
        checkOutput("outstanding_le2", max_out <= 2, 1);
        checkOutput("stall_stability_errs", stall_bad, 0);
    endtask

    initial begin
        for (int i = 0; i < DL; i++) mem[i] = DW'(i);

        vecs[0] = '{8'h10,   4, 0,  7, 0};
        vecs[1] = '{8'hFE,   4, 0,  7, 0};
        vecs[2] = '{8'h00,   1, 0,  4, 0};
        vecs[3] = '{8'h80,   0, 0,  1, 0};
        vecs[4] = '{8'h20,   5, 2, 12, 0};
        vecs[5] = '{8'h40,   3, 0,  6, 2};
        vecs[6] = '{8'h00, 256, 1, -1, 0};

        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        count     = '0;
        m_ready   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_r_en", r_en, 0);
        checkOutput("reset_r_addr", r_addr, 0);
        checkOutput("reset_m_valid", m_valid, 0);
        checkOutput("reset_m_data", m_data, 0);
        rst = 1'b0;

        for (int k = 0; k < 7; k++) applyStimulus(vecs[k]);

        // Reset while the buffer holds two stalled words
        @(negedge clk);
        base_addr = 8'h30;
        count     = 9'd8;
        start     = 1'b1;
        m_ready   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checkOutput("pre_reset_valid", m_valid, 1);
        checkOutput("pre_reset_data", m_data, 16'h0030);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("mid_reset_busy", busy, 0);
        checkOutput("mid_reset_done", done, 0);
        checkOutput("mid_reset_r_en", r_en, 0);
        checkOutput("mid_reset_r_addr", r_addr, 0);
        checkOutput("mid_reset_m_valid", m_valid, 0);
        checkOutput("mid_reset_m_data", m_data, 0);
        @(negedge clk);
        #1;
        checkOutput("post_reset_done", done, 0);
        checkOutput("post_reset_m_valid", m_valid, 0);
        applyStimulus('{8'h00, 1, 0, 4, 0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Streaming read sequencer for the inferred block RAM (`ram`, and `SB_RAM40_4K` on ICE40). On a start command it issues sequential reads over the RAM's synchronous read port (1-cycle read latency, output held while `r_en` is low) and presents the words on a valid/ready output stream, absorbing backpressure without losing or duplicating words. It sits between a RAM instance and any stream consumer (UART TX, display scan-out, DSP input).

## Interface
- `DATA_WIDTH`, 16, RAM word width
- `DATA_LEN`, 256, RAM depth in words; power of two
- `ADDR_W`, `$clog2(DATA_LEN)`, address width (derived, not overridden)

- `clk`  in  1  single clock; RAM read port clocked by the same `clk`
- `rst`  in  1  reset: synchronous, active-high
- `start`  in  1  command pulse; sampled only in IDLE
- `base_addr`  in  ADDR_W  first address, sampled with `start`
- `count`  in  ADDR_W+1  words to read, 0..DATA_LEN, sampled with `start`
- `busy`  out  1  high from cycle after accepted `start` until `done`
- `done`  out  1  one-cycle pulse when the last word is handed off
- `r_en`  out  1  RAM read enable
- `r_addr`  out  ADDR_W  RAM read address
- `r_data`  in  DATA_WIDTH  RAM read data, valid the cycle after `r_en`
- `m_data`  out  DATA_WIDTH  stream data
- `m_valid`  out  1  stream valid
- `m_ready`  in  1  stream ready
- `m_last`  out  1  final word marker (only with `BRAM_READER_LAST_EN`)

## Operation
- FSM: IDLE, RUN, DRAIN.
- IDLE: `start`=1 latches `base_addr`/`count`; `count`≠0 → RUN; `count`=0 → `done` pulse next cycle, stays IDLE, no reads, no stream words.
- RUN: issues read when `issued < count` and `occ + inflight − pop < 2` (occ = skid buffer occupancy 0..2, inflight = read issued last cycle, pop = `m_valid & m_ready`). Each issue: `r_en`=1, `r_addr` = current address, address increments modulo DATA_LEN (wraps DATA_LEN−1 → 0). After final issue → DRAIN.
- DRAIN: no reads; when buffer empty and nothing in flight → `done` pulse, → IDLE.
- `r_data` captured into 2-entry skid buffer the cycle after each issue; never captured otherwise.
- Stream: AXI-style; `m_data`/`m_valid` stable while `m_valid & !m_ready`; `m_valid` never drops without a handshake. Words emerge in address order, exactly `count` of them.
- `start` while `busy` ignored, latched values unchanged.
- `rst` at any point: all state cleared; in-flight read data discarded; no `done`.
- Reset values: `busy`=0, `done`=0, `r_en`=0, `r_addr`=0, `m_valid`=0, `m_data`=0, `m_last`=0.

## Timing
- `start` at cycle T (IDLE) → `busy`=1 and first `r_en` at T+1 → `r_data` at T+2 → `m_valid`=1 at T+3.
- `m_ready` held high: one word per cycle sustained; N words occupy T+3..T+N+2.
- `done` in the cycle after the last handshake; `busy` low in that same cycle; next `start` accepted in that cycle.
- `r_en`, `r_addr`, `busy`, `done` are combinational from registered state and registered occupancy plus `m_ready` (pop term); no path from `r_data` to any output within a cycle.
- `m_ready` low: at most 2 words buffered, reads stall; no overrun.

## Configuration
- `BRAM_READER_LAST_EN` defined: `m_last` port present, high with the final word of the command (count-th handshake), qualified by `m_valid`.
- Undefined: no `m_last` port; buffer width DATA_WIDTH only; behaviour otherwise identical.

## Structure
- Shared package `bram_pkg`: FSM state typedef (IDLE/RUN/DRAIN), default `DATA_WIDTH`/`DATA_LEN` constants.
- One sub-module: `stream_skid2`, 2-entry valid/ready buffer (push, data in, occupancy out, stream out; carries `last` bit when macro defined).
- Top: FSM, address/issue counter, in-flight flag, credit logic.

## Test plan
- RAM preloaded mem[i]=i; start base=0x10 count=4, `m_ready`=1 → 0x10,0x11,0x12,0x13 at T+3..T+6, `done` at T+7, `m_last` on 0x13.
- base=0xFE count=4 → 0xFE,0xFF,0x00,0x01 (wrap).
- count=256, `m_ready` random 50% → exactly 256 words in order, no duplicates, data stable during stalls, ≤2 reads outstanding beyond handshakes.
- count=0 → `done` at T+1, `m_valid` never high, `r_en` never high; `start` during `busy` ignored.
- `rst` asserted mid-RUN with 2 words buffered → next cycle all outputs at reset values; new start base=0 count=1 → single word 0x00.
